// File: rtl/cpu_mem_loader_pkg.sv
// Shared types and constants for the CPU memory loader: the sequencer state
// encoding, the per-memory address steps, and the phase-skipping helper.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_IMEM,
    LD_DMEM,
    RUN,
    DUMP_REQ,
    DUMP_WAIT,
    DUMP_OUT,
    DONE
  } state_t;

  // Instruction memory holds 32-bit words, data memory holds 64-bit words.
  localparam int IMEM_STEP = 4;
  localparam int DMEM_STEP = 8;

  // Picks the first phase after 'cur' whose count is non-zero.
  // nz is {dump, run, dmem, imem}; empty phases are skipped outright.
  function automatic state_t nextPhase(state_t cur, logic [3:0] nz);
    logic [3:0] pending;
    case (cur)
      IDLE, DONE: pending = nz;
      LD_IMEM:    pending = nz & 4'b1110;
      LD_DMEM:    pending = nz & 4'b1100;
      RUN:        pending = nz & 4'b1000;
      default:    pending = 4'b0000;
    endcase
    if (pending[0])      return LD_IMEM;
    else if (pending[1]) return LD_DMEM;
    else if (pending[2]) return RUN;
    else if (pending[3]) return DUMP_REQ;
    else                 return DONE;
  endfunction

endpackage

// File: rtl/cpu_mem_loader_if.sv
// Bundle of every non-clock signal between the host side, the loader and the
// CPU memory ports. 'master' is the loader's view, 'slave' is the host/CPU view.
interface cpu_mem_loader_if #(
  parameter int CNT_W = 32
) ();

  logic             start;
  logic [CNT_W-1:0] imem_words;
  logic [CNT_W-1:0] dmem_words;
  logic [CNT_W-1:0] run_cycles;
  logic [CNT_W-1:0] dump_words;

  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;

  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;

  logic             cpu_enable;

  logic [63:0]      addr_ext;
  logic             wen_ext;
  logic             ren_ext;
  logic [31:0]      wdata_ext;

  logic [63:0]      addr_ext_2;
  logic             wen_ext_2;
  logic             ren_ext_2;
  logic [63:0]      wdata_ext_2;
  logic [63:0]      rdata_ext_2;

  logic             busy;
  logic             done;

  modport master (
    input  start, imem_words, dmem_words, run_cycles, dump_words,
    input  in_valid, in_data, out_ready, rdata_ext_2,
    output in_ready, out_valid, out_data, cpu_enable,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    output busy, done
  );

  modport slave (
    output start, imem_words, dmem_words, run_cycles, dump_words,
    output in_valid, in_data, out_ready, rdata_ext_2,
    input  in_ready, out_valid, out_data, cpu_enable,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    input  busy, done
  );

endinterface

// File: rtl/cpu_mem_loader_stream_writer.sv
// Turns accepted stream words into registered memory writes at base+step*i.
// The address register is also lent out for reads so one memory port has a
// single registered address source; it returns to 0 when idle.
module loader_stream_writer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  parameter int STEP   = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              clear_i,
  input  logic              fire_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CNT_W-1:0]  words_i,
  input  logic [63:0]       base_i,
  input  logic              rd_i,
  input  logic [63:0]       rd_addr_i,
  output logic              wen_o,
  output logic [63:0]       addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              full_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [63:0]       addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next write strobe/address/data and word count from the current handshake.
  always_comb begin
    cnt_d  = cnt_q;
    wen_d  = 1'b0;
    addr_d = '0;
    data_d = '0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (fire_i) begin
      wen_d  = 1'b1;
      addr_d = base_i + (64'(cnt_q) * 64'(STEP));
      data_d = data_i;
      cnt_d  = cnt_q + CNT_W'(1);
    end else if (rd_i) begin
      addr_d = rd_addr_i;
    end
  end

  // Registered memory port and word counter.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q  <= '0;
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign wen_o  = wen_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign last_o = fire_i && ((cnt_q + CNT_W'(1)) == words_i);
  assign full_o = (cnt_q == words_i);

endmodule

// File: rtl/cpu_mem_loader.sv
// Host-side sequencer: loads imem, loads dmem, runs the core for a fixed
// number of cycles, then streams dmem back out one word per read.
module cpu_mem_loader
  import loader_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter int          RD_LAT    = 1,
  parameter logic [63:0] IMEM_BASE = 64'd0,
  parameter logic [63:0] DMEM_BASE = 64'd0
) (
  input  logic                 clk,
  input  logic                 arst,
  cpu_mem_loader_if.master     bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] imemWords_q, dmemWords_q, runCycles_q, dumpWords_q;
  logic [CNT_W-1:0] runCnt_q, runCnt_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0] dumpCnt_q, dumpCnt_d;
  logic [63:0]      outData_q, outData_d;
  logic             inReady_q, inReady_d;
  logic             outValid_q, outValid_d;
  logic             cpuEnable_q, cpuEnable_d;
  logic             ren2_q, ren2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             startAcc;
  logic [3:0]       startNz, heldNz;
  logic             imHs, dmHs, imLast, dmLast, imFull, dmFull, outHs;
  logic [63:0]      rdAddr;

  assign startAcc = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign startNz  = {bus.dump_words != '0, bus.run_cycles != '0,
                     bus.dmem_words != '0, bus.imem_words != '0};
  assign heldNz   = {dumpWords_q != '0, runCycles_q != '0,
                     dmemWords_q != '0, imemWords_q != '0};
  assign imHs     = (state_q == LD_IMEM) && inReady_q && bus.in_valid;
  assign dmHs     = (state_q == LD_DMEM) && inReady_q && bus.in_valid;
  assign outHs    = outValid_q && bus.out_ready;
  assign rdAddr   = DMEM_BASE + (64'(dumpCnt_d) * 64'(DMEM_STEP));

  loader_stream_writer #(
    .DATA_W (32),
    .CNT_W  (CNT_W),
    .STEP   (IMEM_STEP)
  ) uImemWriter (
    .clk_i     (clk),
    .arst_i    (arst),
    .clear_i   (startAcc),
    .fire_i    (imHs),
    .data_i    (bus.in_data[31:0]),
    .words_i   (imemWords_q),
    .base_i    (IMEM_BASE),
    .rd_i      (1'b0),
    .rd_addr_i (64'd0),
    .wen_o     (bus.wen_ext),
    .addr_o    (bus.addr_ext),
    .data_o    (bus.wdata_ext),
    .last_o    (imLast),
    .full_o    (imFull)
  );

  loader_stream_writer #(
    .DATA_W (64),
    .CNT_W  (CNT_W),
    .STEP   (DMEM_STEP)
  ) uDmemWriter (
    .clk_i     (clk),
    .arst_i    (arst),
    .clear_i   (startAcc),
    .fire_i    (dmHs),
    .data_i    (bus.in_data),
    .words_i   (dmemWords_q),
    .base_i    (DMEM_BASE),
    .rd_i      (ren2_d),
    .rd_addr_i (rdAddr),
    .wen_o     (bus.wen_ext_2),
    .addr_o    (bus.addr_ext_2),
    .data_o    (bus.wdata_ext_2),
    .last_o    (dmLast),
    .full_o    (dmFull)
  );

  // Next state, phase counters and the registered-output next values.
  // A load phase leaves only after its final write has been presented, so
  // a write strobe never overlaps the run or the first dump read.
  always_comb begin
    state_d   = state_q;
    runCnt_d  = runCnt_q;
    waitCnt_d = waitCnt_q;
    dumpCnt_d = dumpCnt_q;
    outData_d = outData_q;
    case (state_q)
      IDLE, DONE: begin
        if (startAcc) begin
          state_d   = nextPhase(IDLE, startNz);
          dumpCnt_d = '0;
        end
      end
      LD_IMEM: if (imFull) state_d = nextPhase(LD_IMEM, heldNz);
      LD_DMEM: if (dmFull) state_d = nextPhase(LD_DMEM, heldNz);
      RUN: begin
        if (runCnt_q <= CNT_W'(1)) state_d = nextPhase(RUN, heldNz);
        else runCnt_d = runCnt_q - CNT_W'(1);
      end
      DUMP_REQ: state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        if (waitCnt_q == '0) begin
          state_d   = DUMP_OUT;
          outData_d = bus.rdata_ext_2;
        end else begin
          waitCnt_d = waitCnt_q - CNT_W'(1);
        end
      end
      DUMP_OUT: begin
        if (outHs) begin
          dumpCnt_d = dumpCnt_q + CNT_W'(1);
          state_d   = (dumpCnt_d == dumpWords_q) ? DONE : DUMP_REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == RUN) && (state_q != RUN))
      runCnt_d = startAcc ? bus.run_cycles : runCycles_q;
    if ((state_d == DUMP_WAIT) && (state_q != DUMP_WAIT))
      waitCnt_d = CNT_W'(RD_LAT - 1);

    inReady_d   = ((state_d == LD_IMEM) && !imLast) ||
                  ((state_d == LD_DMEM) && !dmLast);
    cpuEnable_d = (state_d == RUN);
    ren2_d      = (state_d == DUMP_REQ);
    outValid_d  = (state_d == DUMP_OUT);
    busy_d      = !((state_d == IDLE) || (state_d == DONE));
    done_d      = (state_d == DONE);
  end

  // State, counters and all sequencer outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      runCnt_q    <= '0;
      waitCnt_q   <= '0;
      dumpCnt_q   <= '0;
      outData_q   <= '0;
      inReady_q   <= 1'b0;
      outValid_q  <= 1'b0;
      cpuEnable_q <= 1'b0;
      ren2_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      runCnt_q    <= runCnt_d;
      waitCnt_q   <= waitCnt_d;
      dumpCnt_q   <= dumpCnt_d;
      outData_q   <= outData_d;
      inReady_q   <= inReady_d;
      outValid_q  <= outValid_d;
      cpuEnable_q <= cpuEnable_d;
      ren2_q      <= ren2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Counts are captured once per accepted start and held for the whole sequence.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      imemWords_q <= '0;
      dmemWords_q <= '0;
      runCycles_q <= '0;
      dumpWords_q <= '0;
    end else if (startAcc) begin
      imemWords_q <= bus.imem_words;
      dmemWords_q <= bus.dmem_words;
      runCycles_q <= bus.run_cycles;
      dumpWords_q <= bus.dump_words;
    end
  end

  assign bus.in_ready   = inReady_q;
  assign bus.out_valid  = outValid_q;
  assign bus.out_data   = outData_q;
  assign bus.cpu_enable = cpuEnable_q;
  assign bus.ren_ext    = 1'b0;
  assign bus.ren_ext_2  = ren2_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
